// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Handshake bundle between a pipeline register stage and its neighbours.
//
// Signals (named from the stage's point of view):
//   i_valid     upstream offers i_data
//   o_ready     stage accepts i_data this cycle
//   i_data      upstream payload (DATA_W bits)
//   i_flush     discard every held and incoming entry
//   o_valid     o_data is valid for the downstream stage
//   i_ready     downstream accepts o_data
//   o_data      downstream payload (DATA_W bits)
//   o_stall_cnt cycles spent with o_valid=1 and i_ready=0 (CNT_W bits)
//
// Modports:
//   slave  - the register stage itself
//   master - the surrounding environment (upstream producer plus downstream
//            consumer), which drives the i_* side and observes the o_* side
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic              i_flush;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_stall_cnt;

    modport slave (
        input  i_valid, i_data, i_flush, i_ready,
        output o_ready, o_valid, o_data, o_stall_cnt
    );

    modport master (
        output i_valid, i_data, i_flush, i_ready,
        input  o_ready, o_valid, o_data, o_stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline register for one packed inter-stage bundle (IF/ID,
// ID/EX, ...). One cycle of latency, one transfer per cycle, flush for branch
// redirects and a saturating stall counter for performance monitoring.
//
// Ports:
//   i_clk   clock, all state changes on its rising edge
//   i_rst_n asynchronous active-low reset
//   bus     pipe_stage_reg_if.slave: i_valid/o_ready/i_data upstream,
//           o_valid/i_ready/o_data downstream, i_flush, o_stall_cnt
//
// Parameters:
//   DATA_W  payload width
//   CNT_W   stall counter width
//   BUBBLE  payload value presented after reset or flush
//
// Build option:
//   PIPE_STAGE_SKID_EN undefined - single entry, o_ready combinational
//                                  (i_ready | ~o_valid)
//   PIPE_STAGE_SKID_EN defined   - main + skid entries (EMPTY/ONE/TWO FSM),
//                                  o_ready registered as "skid empty"
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W = 32,
    parameter int                CNT_W  = 16,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input logic              i_clk,
    input logic              i_rst_n,
    pipe_stage_reg_if.slave  bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    logic             accept;
    logic             drain;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_p0;

    assign accept = bus.i_valid & bus.o_ready;
    assign drain  = bus.o_valid & bus.i_ready;
    assign stall  = bus.o_valid & ~bus.i_ready;

    // ---- stall counter stage ----
    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_p0 <= '0;
        end else if (stall) begin
            stall_cnt_p0 <= sat_inc(stall_cnt_p0);
        end
    end

    assign bus.o_stall_cnt = stall_cnt_p0;

`ifdef PIPE_STAGE_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_p0;
    state_t            state_nxt;
    logic              rdy_p0;
    logic              rdy_nxt;
    logic [DATA_W-1:0] main_p0;
    logic [DATA_W-1:0] skid_p0;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid_in;

    // ---- state register stage ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_p0 <= EMPTY;
            rdy_p0   <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            rdy_p0   <= rdy_nxt;
        end
    end

    // Next state. Accept in TWO cannot happen because o_ready is low there.
    always_comb begin
        state_nxt = state_p0;
        if (bus.i_flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state_p0)
                EMPTY: if (accept) state_nxt = ONE;
                ONE: begin
                    if (accept && !drain)      state_nxt = TWO;
                    else if (!accept && drain) state_nxt = EMPTY;
                end
                TWO:   if (drain) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Datapath steering. o_ready is registered, so it is computed from the
    // state we are about to enter rather than from downstream i_ready.
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        rdy_nxt        = (state_nxt != TWO);
        if (!bus.i_flush) begin
            case (state_p0)
                EMPTY: load_main_in = accept;
                ONE: begin
                    load_main_in = accept & drain;
                    load_skid_in = accept & ~drain;
                end
                TWO:   load_main_skid = drain;
                default: ;
            endcase
        end
    end

    // ---- payload stage ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_p0 <= BUBBLE;
            skid_p0 <= BUBBLE;
        end else if (bus.i_flush) begin
            main_p0 <= BUBBLE;
            skid_p0 <= BUBBLE;
        end else begin
            if (load_main_in)   main_p0 <= bus.i_data;
            if (load_main_skid) main_p0 <= skid_p0;
            if (load_skid_in)   skid_p0 <= bus.i_data;
        end
    end

    assign bus.o_valid = (state_p0 != EMPTY);
    assign bus.o_data  = main_p0;
    assign bus.o_ready = rdy_p0;

`else

    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic              rdy_en_p0;

    // ---- single-entry stage ----
    // rdy_en_p0 keeps o_ready low in reset and until the first edge after it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p0    <= 1'b0;
            data_p0   <= BUBBLE;
            rdy_en_p0 <= 1'b0;
        end else begin
            rdy_en_p0 <= 1'b1;
            if (bus.i_flush) begin
                vld_p0  <= 1'b0;
                data_p0 <= BUBBLE;
            end else if (accept) begin
                vld_p0  <= 1'b1;
                data_p0 <= bus.i_data;
            end else if (drain) begin
                vld_p0  <= 1'b0;
            end
        end
    end

    assign bus.o_valid = vld_p0;
    assign bus.o_data  = data_p0;
    assign bus.o_ready = rdy_en_p0 & (bus.i_ready | ~vld_p0);

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        bit          vld;
        logic [31:0] data;
        bit          rdy;
        bit          flush;
        bit          exp_ordy;
        bit          exp_ov;
        bit          chk_d;
        logic [31:0] exp_od;
        logic [15:0] exp_cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    logic [31:0] sb_q[$];
    logic [31:0] sb_exp;
    vec_t tbl[$];

    pipe_stage_reg_if #(.DATA_W(32), .CNT_W(16)) bus ();

    pipe_stage_reg #(.DATA_W(32), .CNT_W(16), .BUBBLE(32'h0)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Scoreboard: accepted payloads queue up, drained payloads are checked
    // against the queue front. Flush and reset empty the queue.
    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n || bus.i_flush) begin
            sb_q.delete();
        end else begin
            if (bus.o_valid && bus.i_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got 0x%0h, expected no output", bus.o_data);
                end else begin
                    sb_exp = sb_q.pop_front();
                    chk("sb_order", bus.o_data, sb_exp);
                end
            end
            if (bus.i_valid && bus.o_ready)
                sb_q.push_back(bus.i_data);
        end
    end

    function automatic vec_t mk(bit vld, logic [31:0] data, bit rdy, bit flush, bit eordy,
                                bit eov, bit chkd, logic [31:0] eod, logic [15:0] ecnt);
        vec_t v;
        v.vld = vld; v.data = data; v.rdy = rdy; v.flush = flush;
        v.exp_ordy = eordy; v.exp_ov = eov; v.chk_d = chkd; v.exp_od = eod; v.exp_cnt = ecnt;
        return v;
    endfunction

    // Drive one vector, check o_ready before the edge, state after it.
    task automatic apply(input vec_t v, input string nm);
        bus.i_valid = v.vld;
        bus.i_data  = v.data;
        bus.i_ready = v.rdy;
        bus.i_flush = v.flush;
        #1;
        chk({nm, ".o_ready"}, 32'(bus.o_ready), 32'(v.exp_ordy));
        @(posedge clk);
        #1;
        chk({nm, ".o_valid"}, 32'(bus.o_valid), 32'(v.exp_ov));
        if (v.chk_d) chk({nm, ".o_data"}, bus.o_data, v.exp_od);
        chk({nm, ".o_stall_cnt"}, 32'(bus.o_stall_cnt), 32'(v.exp_cnt));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b1;
        bus.i_flush = 1'b0;

        // stream 0x1..0x8 back to back
        for (int k = 1; k <= 8; k++) tbl.push_back(mk(1, 32'(k), 1, 0, 1, 1, 1, 32'(k), 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
        // accept 0xA, then stall 5 cycles with 0xB offered
        tbl.push_back(mk(1, 32'hA, 1, 0, 1, 1, 1, 32'hA, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(1, 32'hB, 0, 0, SKID && (i == 1), 1, 1, 32'hA, 16'(i)));
        tbl.push_back(mk(0, 0, 1, 0, !SKID, SKID, SKID, 32'hB, 5));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 5));
        // fill, then flush while 0xC is offered
        tbl.push_back(mk(1, 32'h11, 0, 0, 1, 1, 1, 32'h11, 5));
        tbl.push_back(mk(1, 32'h12, 0, 0, SKID, 1, 1, 32'h11, 6));
        tbl.push_back(mk(1, 32'hC, 0, 1, 0, 0, 1, 32'h0, 7));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 7));
        // flush beats a simultaneous accept and drain
        tbl.push_back(mk(1, 32'h13, 1, 0, 1, 1, 1, 32'h13, 7));
        tbl.push_back(mk(1, 32'h14, 1, 1, 1, 0, 1, 32'h0, 7));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 7));

        // reset state
        #3;
        chk("rst.o_valid", 32'(bus.o_valid), 32'h0);
        chk("rst.o_data", bus.o_data, 32'h0);
        chk("rst.o_stall_cnt", 32'(bus.o_stall_cnt), 32'h0);
        chk("rst.o_ready", 32'(bus.o_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.o_ready_before_edge", 32'(bus.o_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("rel.o_ready_after_edge", 32'(bus.o_ready), 32'h1);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // stall counter saturation
        apply(mk(1, 32'h21, 1, 0, 1, 1, 1, 32'h21, 7), "sat_load");
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat.o_stall_cnt", 32'(bus.o_stall_cnt), 32'hFFFF);
        chk("sat.o_data", bus.o_data, 32'h21);
        chk("sat.o_valid", 32'(bus.o_valid), 32'h1);
        apply(mk(0, 0, 1, 0, 1, 0, 0, 0, 16'hFFFF), "sat_drain");

        // asynchronous reset while holding 0xD
        apply(mk(1, 32'hD, 0, 0, 1, 1, 1, 32'hD, 16'hFFFF), "hold_d");
        bus.i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst.o_valid", 32'(bus.o_valid), 32'h0);
        chk("arst.o_data", bus.o_data, 32'h0);
        chk("arst.o_stall_cnt", 32'(bus.o_stall_cnt), 32'h0);
        chk("arst.o_ready", 32'(bus.o_ready), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        #1;
        chk("arel.o_ready_before_edge", 32'(bus.o_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("arel.o_ready_after_edge", 32'(bus.o_ready), 32'h1);
        apply(mk(1, 32'hE, 1, 0, 1, 1, 1, 32'hE, 0), "post_rst_e");
        apply(mk(0, 0, 1, 0, 1, 0, 0, 0, 0), "post_rst_idle");
        chk("sb_leftover", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
